// File: rtl/ackermann_sched.sv
// ============================================================================
//  Module   : ackermann_sched
//  Function : Two-requester round-robin job scheduler for an Ackermann engine.
//             Optional watchdog compiled in with `define ACK_SCHED_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ackermann_sched #(
  parameter int MSIZE          = 3,
  parameter int NSIZE          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [MSIZE-1:0] req0_m,
  input  logic [NSIZE-1:0] req0_n,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [MSIZE-1:0] req1_m,
  input  logic [NSIZE-1:0] req1_n,
  output logic             req1_ready,
  output logic             eng_start,
  output logic [MSIZE-1:0] eng_m,
  output logic [NSIZE-1:0] eng_n,
  input  logic             eng_done,
  input  logic [15:0]      eng_result,
  output logic             eng_abort,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [15:0]      rsp_data,
  output logic             rsp_err,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [7:0]       job_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]       r_state;
  logic [MSIZE-1:0] r_m;
  logic [NSIZE-1:0] r_n;
  logic             r_id;
  logic             r_last;
  logic [15:0]      r_rsp_data;
  logic [7:0]       r_job_count;

  logic w_idle;
  logic w_grant_id;
  logic w_accept;
  logic w_expire;

  assign w_idle = (r_state == S_IDLE);

  // Tie goes to the requester not served last; otherwise whoever is asking.
  assign w_grant_id = (req0_valid && req1_valid) ? ~r_last : ~req0_valid;
  assign w_accept   = w_idle && (req0_valid || req1_valid);

  assign req0_ready = w_idle && req0_valid && !w_grant_id;
  assign req1_ready = w_idle && req1_valid &&  w_grant_id;

`ifdef ACK_SCHED_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_rsp_err;

  // Expiry fires in the TIMEOUT_CYCLES-th WAIT cycle; a done in that cycle wins.
  assign w_expire = (r_state == S_WAIT) && !eng_done &&
                    (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog    <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_wdog <= '0;
      end else if ((r_state == S_WAIT) && !eng_done) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (r_state == S_WAIT) begin
        if (eng_done) begin
          r_rsp_err <= 1'b0;
        end else if (w_expire) begin
          r_rsp_err <= 1'b1;
        end
      end
    end
  end

  assign eng_abort = w_expire;
  assign rsp_err   = r_rsp_err;
`else
  assign w_expire  = 1'b0;
  assign eng_abort = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_m         <= '0;
      r_n         <= '0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_rsp_data  <= 16'h0000;
      r_job_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_m     <= w_grant_id ? req1_m : req0_m;
            r_n     <= w_grant_id ? req1_n : req0_n;
            r_id    <= w_grant_id;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            r_rsp_data <= eng_result;
            r_state    <= S_RESP;
          end else if (w_expire) begin
            r_rsp_data <= 16'hFFFF;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_job_count <= r_job_count + 8'd1;
            r_last      <= r_id;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign eng_start = (r_state == S_LAUNCH);
  assign eng_m     = r_m;
  assign eng_n     = r_n;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = !w_idle;
  assign job_count = r_job_count;

endmodule

`default_nettype wire

// File: tb/tb_ackermann_sched.sv
// ============================================================================
//  Module   : tb_ackermann_sched
//  Function : Self-checking bench for ackermann_sched with a behavioural model
//             of arbitration, Ackermann results and response counting.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ackermann_sched;

  localparam int TO = 16;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_m, req1_m;
  logic [3:0]  req0_n, req1_n;
  logic        req0_ready, req1_ready;
  logic        eng_start, eng_done, eng_abort;
  logic [2:0]  eng_m;
  logic [3:0]  eng_n;
  logic [15:0] eng_result;
  logic        rsp_valid, rsp_id, rsp_err, rsp_ready, busy;
  logic [15:0] rsp_data;
  logic [7:0]  job_count;

  int n_vec = 0;
  int n_err = 0;
  int m_last = 1;
  int exp_cnt = 0;

  ackermann_sched #(.MSIZE(3), .NSIZE(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_m(req0_m), .req0_n(req0_n), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_m(req1_m), .req1_n(req1_n), .req1_ready(req1_ready),
    .eng_start(eng_start), .eng_m(eng_m), .eng_n(eng_n),
    .eng_done(eng_done), .eng_result(eng_result), .eng_abort(eng_abort),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .busy(busy), .job_count(job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Closed forms of A(m,n) for m <= 3, truncated to the 16-bit result bus.
  function automatic logic [15:0] ack(input int m, input int n);
    int r;
    case (m)
      0:       r = n + 1;
      1:       r = n + 2;
      2:       r = 2 * n + 3;
      default: r = (1 << (n + 3)) - 3;
    endcase
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last  = 1;
    exp_cnt = 0;
  endtask

  task automatic run_job(input bit v0, input bit v1, input int m0, input int n0,
                         input int m1, input int n1, input int dly, input int stall,
                         input bit to);
    int gid, em, en, wc;
    logic [15:0] exp_data;
    logic        exp_err;
    gid = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
    em  = gid ? m1 : m0;
    en  = gid ? n1 : n0;
    exp_data = to ? 16'hFFFF : ack(em, en);
    exp_err  = to;

    req0_valid = v0; req0_m = 3'(m0); req0_n = 4'(n0);
    req1_valid = v1; req1_m = 3'(m1); req1_n = 4'(n1);
    #1;
    chk("busy_idle", busy, 0);
    chk("ready0", req0_ready, (v0 && gid == 0));
    chk("ready1", req1_ready, (v1 && gid == 1));
    tick();
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("eng_start", eng_start, 1);
    chk("eng_m", eng_m, em);
    chk("eng_n", eng_n, en);
    chk("busy_launch", busy, 1);
    tick();
    #1;
    chk("start_once", eng_start, 0);
    if (to) begin
      wc = 0;
      for (int k = 1; k <= TO + 8; k++) begin
        if (eng_abort) begin
          wc = k;
          break;
        end
        chk("rsp_early_to", rsp_valid, 0);
        tick();
        #1;
      end
      chk("abort_cycle", wc, TO);
      tick();
      #1;
      chk("abort_once", eng_abort, 0);
    end else begin
      for (int i = 0; i < dly; i++) begin
        chk("rsp_early", rsp_valid, 0);
        tick();
        #1;
      end
      eng_done = 1; eng_result = ack(em, en);
      tick();
      eng_done = 0; eng_result = 16'($urandom);
      #1;
      chk("abort_none", eng_abort, 0);
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, gid);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", rsp_err, exp_err);
    for (int s = 0; s < stall; s++) begin
      tick();
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      eng_done = 1'($urandom); eng_result = 16'($urandom);
      #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, gid);
      chk("stall_data", rsp_data, exp_data);
      chk("stall_err", rsp_err, exp_err);
      chk("stall_busy", busy, 1);
      chk("stall_rdy", {req0_ready, req1_ready}, 0);
    end
    tick();
    eng_done = 0;
    rsp_ready = 1; req0_valid = 1; req1_valid = 1;
    #1;
    chk("xfer_no_accept", {req0_ready, req1_ready}, 0);
    tick();
    rsp_ready = 0; req0_valid = 0; req1_valid = 0;
    exp_cnt = (exp_cnt + 1) % 256;
    m_last  = gid;
    #1;
    chk("rsp_drop", rsp_valid, 0);
    chk("busy_done", busy, 0);
    chk("job_count", job_count, exp_cnt);
  endtask

  initial begin
    int starts, done;
    bit pend;
    int hn;
    reset = 1; req0_valid = 0; req1_valid = 0; req0_m = 0; req0_n = 0;
    req1_m = 0; req1_n = 0; eng_done = 0; eng_result = 0; rsp_ready = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_job_count", job_count, 0);
    chk("rst_outs", {eng_start, eng_abort, rsp_err, rsp_id, req0_ready, req1_ready}, 0);
    chk("rst_eng_mn", {eng_m, eng_n}, 0);
    reset = 0;
    model_reset();

    // Single job: A(2,3) = 9.
    run_job(1, 0, 2, 3, 0, 0, 0, 0, 0);

    // Fresh reset, then a tie: requester 0 wins first.
    #2 reset = 1; #3 reset = 0;
    model_reset();
    run_job(1, 1, 0, 5, 1, 1, 1, 0, 0);
    run_job(0, 1, 0, 0, 1, 1, 0, 5, 0);

    for (int j = 0; j < 40; j++) begin
      int sel;
      sel = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) begin
        eng_done = 1; eng_result = 16'($urandom);
        tick();
        eng_done = 0;
        #1;
        chk("spur_busy", busy, 0);
        chk("spur_rsp", rsp_valid, 0);
      end
      run_job(sel[0], sel[1], $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 4), $urandom_range(0, 3), 0);
    end

`ifdef ACK_SCHED_TIMEOUT_EN
    run_job(0, 1, 0, 0, 2, 2, 0, 2, 1);
    run_job(1, 0, 3, 4, 0, 0, TO - 1, 0, 0);
`endif

    // Reset landing mid-WAIT, then a late done.
    req0_valid = 1; req0_m = 3'd1; req0_n = 4'd2;
    tick();
    req0_valid = 0;
    tick();
    #1;
    reset = 1;
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_count", job_count, 0);
    chk("rstw_rsp", rsp_valid, 0);
    chk("rstw_start", eng_start, 0);
    @(posedge clk);
    #2 reset = 0;
    model_reset();
    eng_done = 1; eng_result = 16'h1234;
    tick();
    eng_done = 0;
    #1;
    chk("late_done_rsp", rsp_valid, 0);
    chk("late_done_busy", busy, 0);
    chk("late_done_data", rsp_data, 0);

    // Requester 1 held valid through 256 completions.
    hn = $urandom_range(0, 15);
    req1_valid = 1; req1_m = 3'd1; req1_n = 4'(hn); rsp_ready = 1;
    pend = 0; starts = 0; done = 0;
    for (int c = 0; c < 3000 && done < 256; c++) begin
      tick();
      eng_done = pend; eng_result = ack(1, hn); pend = 0;
      #1;
      if (eng_start) begin
        starts++;
        pend = 1;
      end
      if (rsp_valid) begin
        done++;
        if (done == 1 || done == 256) begin
          chk("hold_id", rsp_id, 1);
          chk("hold_data", rsp_data, ack(1, hn));
        end
        if (done == 256) begin
          chk("hold_pre_wrap", job_count, (exp_cnt + 255) % 256);
          req1_valid = 0;
        end
      end
    end
    eng_done = 0;
    tick();
    rsp_ready = 0;
    tick();
    #1;
    exp_cnt = (exp_cnt + done) % 256;
    chk("hold_done", done, 256);
    chk("hold_starts", starts, 256);
    chk("hold_wrap", job_count, exp_cnt);
    chk("hold_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ackermann_sched.md
ACKERMANN_SCHED -- requirements
Module: ackermann_sched

Interface
REQ-001 Parameters SHALL be: MSIZE, default 3, m operand width; NSIZE, default 4, n operand width; TIMEOUT_CYCLES, default 65535, watchdog limit in clk cycles.
REQ-002 Ports SHALL be, in order:
  clk  in  1  single clock, all state on posedge
  reset  in  1  asynchronous, active-high
  req0_valid  in  1  requester 0 job request
  req0_m  in  MSIZE  requester 0 m operand
  req0_n  in  NSIZE  requester 0 n operand
  req0_ready  out  1  requester 0 accepted (transfer on valid&ready)
  req1_valid, req1_m, req1_n, req1_ready  as requester 0, for requester 1
  eng_start  out  1  one-cycle launch pulse to the Ackermann engine
  eng_m  out  MSIZE  operand m to engine, stable from eng_start to completion
  eng_n  out  NSIZE  operand n to engine, stable from eng_start to completion
  eng_done  in  1  engine result valid (sampled only in WAIT)
  eng_result  in  16  engine result
  eng_abort  out  1  one-cycle engine kill pulse on timeout
  rsp_valid  out  1  response available
  rsp_id  out  1  requester index of response
  rsp_data  out  16  A(m,n) result
  rsp_err  out  1  response is a timeout error
  rsp_ready  in  1  response consumed (transfer on valid&ready)
  busy  out  1  high in any state other than IDLE
  job_count  out  8  completed responses, wraps 255->0

Function
REQ-003 FSM states SHALL be IDLE, LAUNCH, WAIT, RESP; one job in flight at a time.
REQ-004 IDLE: reqX_ready SHALL be combinational, high only for the granted requester while in IDLE and its valid high; on transfer, m, n, id latch and state -> LAUNCH.
REQ-005 Arbitration SHALL be round-robin: with both valid, grant the requester not served last; with one valid, grant it.
REQ-006 LAUNCH: eng_start SHALL be high exactly one cycle; state -> WAIT next cycle.
REQ-007 WAIT: on eng_done, eng_result SHALL latch into rsp_data, rsp_err = 0, state -> RESP.
REQ-008 RESP: rsp_valid, rsp_id, rsp_data, rsp_err SHALL hold stable until rsp_ready; on transfer, job_count increments, last-served updates, state -> IDLE.
REQ-009 Minimum request-to-rsp_valid latency SHALL be 3 cycles (accept, LAUNCH, WAIT with eng_done high in its first cycle).
REQ-010 A new request SHALL NOT be accepted in the cycle rsp_valid&rsp_ready transfers; earliest acceptance is the following cycle.
REQ-011 eng_done outside WAIT SHALL be ignored.
REQ-012 job_count SHALL wrap modulo 256 with no flag.

Reset
REQ-013 Asserting reset SHALL immediately force IDLE, regardless of current state, including mid-WAIT.
REQ-014 Reset values SHALL be: all outputs 0, rsp_data 16'h0000, job_count 0, last-served = requester 1 (so requester 0 wins the first tie), watchdog counter 0.
REQ-015 The first acceptance after deassertion SHALL occur no earlier than the first posedge clk with reset low.

Configuration
REQ-016 Macro ACK_SCHED_TIMEOUT_EN SHALL compile in the watchdog.
REQ-017 With ACK_SCHED_TIMEOUT_EN defined: a counter clears on entering WAIT and counts WAIT cycles; on reaching TIMEOUT_CYCLES without eng_done, eng_abort pulses one cycle, rsp_data = 16'hFFFF, rsp_err = 1, state -> RESP; eng_done in the expiry cycle wins (normal result, no abort).
REQ-018 Without ACK_SCHED_TIMEOUT_EN: no counter, WAIT is unbounded, eng_abort and rsp_err tied 0.

Verification
REQ-019 Req0 m=2, n=3, engine model returns 9 -> rsp_valid, rsp_id=0, rsp_data=16'h0009, rsp_err=0, job_count=1.
REQ-020 Both valid in the same cycle after reset (req0 0,5; req1 1,1) -> req0 served first, rsp_data=16'h0006; then req1, rsp_data=16'h0003.
REQ-021 rsp_ready low 5 cycles in RESP -> rsp outputs unchanged, req0_ready/req1_ready low, busy high throughout.
REQ-022 Macro defined, TIMEOUT_CYCLES=16, eng_done never asserted -> eng_abort pulse after 16 WAIT cycles, rsp_err=1, rsp_data=16'hFFFF.
REQ-023 Reset asserted in WAIT -> state IDLE, busy=0, job_count=0 asynchronously; a late eng_done is ignored.
REQ-024 Req1 held valid through 256 completions -> job_count wraps to 0, eng_start pulses exactly once per job.
